rr_grant_sequencer_4: RTL and testbench



---
 rtl/rr_grant_sequencer_4.sv | 125 ++++++++++++
 tb/tb_rr_grant_sequencer_4.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_sequencer_4.sv
// Four-requestor round-robin grant sequencer with bounded hold time and a
// one-cycle break-before-make gap between grants; drives a 2-to-4 enable decoder.
module rr_grant_sequencer_4 #(
    parameter  int HOLD_MAX = 16,
    localparam int CW       = $clog2(HOLD_MAX)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [1:0] grant_idx,
    output logic       grant_en,
    output logic       timeout,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [1:0]    last_idx_reg, last_idx_next;
    logic [1:0]    grant_idx_reg, grant_idx_next;
    logic          grant_en_reg, grant_en_next;
    logic          timeout_reg, timeout_next;
    logic          busy_reg, busy_next;

    // Candidate indices in search order: last_idx+1, +2, +3, +0 (mod 4).
    logic [1:0] cand [4];
    logic       win_found;
    logic [1:0] win_idx;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cand
            assign cand[gi] = last_idx_reg + 2'(gi + 1);
        end
    endgenerate

    // Scan from lowest priority upward so the earliest candidate overwrites last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[cand[i]]) begin
                win_found = 1'b1;
                win_idx   = cand[i];
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        last_idx_next  = last_idx_reg;
        grant_idx_next = grant_idx_reg;
        timeout_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (win_found) begin
                    state_next     = ST_GRANT;
                    grant_idx_next = win_idx;
                    last_idx_next  = win_idx;
                end
            end
            ST_GRANT: begin
                // Release takes precedence over the hold limit.
                if (!req[grant_idx_reg]) begin
                    state_next = ST_GAP;
                    cnt_next   = '0;
                end else if (cnt_reg == CW'(HOLD_MAX - 1)) begin
                    state_next   = ST_GAP;
                    cnt_next     = '0;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_GAP: begin
                cnt_next = '0;
                if (win_found) begin
                    state_next     = ST_GRANT;
                    grant_idx_next = win_idx;
                    last_idx_next  = win_idx;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        grant_en_next = (state_next == ST_GRANT);
        busy_next     = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            last_idx_reg  <= 2'd3;
            grant_idx_reg <= 2'd0;
            grant_en_reg  <= 1'b0;
            timeout_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            last_idx_reg  <= last_idx_next;
            grant_idx_reg <= grant_idx_next;
            grant_en_reg  <= grant_en_next;
            timeout_reg   <= timeout_next;
            busy_reg      <= busy_next;
        end
    end

    assign grant_idx = grant_idx_reg;
    assign grant_en  = grant_en_reg;
    assign timeout   = timeout_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_rr_grant_sequencer_4.sv
// Self-checking bench for rr_grant_sequencer_4 (HOLD_MAX=4) against a
// grant-length reference model, with directed scenarios and random traffic.
module tb_rr_grant_sequencer_4;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [1:0] grant_idx;
    logic       grant_en;
    logic       timeout;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model: whether a grant is live, who holds it, how many cycles
    // it has lasted, whether this is the gap cycle, and the priority pointer.
    bit m_en, m_gap, m_to;
    int m_idx, m_ptr, m_held;

    rr_grant_sequencer_4 #(.HOLD_MAX(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .grant_idx (grant_idx),
        .grant_en  (grant_en),
        .timeout   (timeout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_en = 0; m_gap = 0; m_to = 0; m_idx = 0; m_ptr = 3; m_held = 0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        m_to = 0;
        if (rst) begin
            model_reset();
        end else if (m_en) begin
            if (!r[m_idx]) begin
                m_en = 0; m_gap = 1;
            end else if (m_held == HOLD) begin
                m_en = 0; m_gap = 1; m_to = 1;
            end else begin
                m_held++;
            end
        end else begin
            m_gap = 0;
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (r[c]) begin
                    m_en = 1; m_idx = c; m_ptr = c; m_held = 1;
                    break;
                end
            end
        end
    endtask

    // One clock: drive req, advance the model at the edge, settle 1ns after.
    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(4'b0000);
        step(4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(4'b0000);
            checks++;
            if ({grant_en, busy, grant_idx, timeout} !== 5'b00000) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got en=%b busy=%b idx=%0d to=%b want all 0",
                         i, grant_en, busy, grant_idx, timeout);
            end
        end
    endtask

    task automatic test_single_release();
        for (int i = 0; i < 3; i++) begin
            step(4'b0100);
            checks++;
            if (grant_en !== 1'b1 || grant_idx !== 2'd2 || timeout !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL single_grant cyc=%0d got en=%b idx=%0d to=%b busy=%b want en=1 idx=2 to=0 busy=1",
                         i, grant_en, grant_idx, timeout, busy);
            end
        end
        step(4'b0000);
        checks++;
        if (grant_en !== 1'b0 || busy !== 1'b1 || timeout !== 1'b0 || grant_idx !== 2'd2) begin
            errors++;
            $display("FAIL single_gap got en=%b busy=%b to=%b idx=%0d want en=0 busy=1 to=0 idx=2",
                     grant_en, busy, timeout, grant_idx);
        end
        step(4'b0000);
        checks++;
        if (grant_en !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got en=%b busy=%b to=%b want 0 0 0", grant_en, busy, timeout);
        end
    endtask

    task automatic test_all_hold();
        int starts[$];
        int tos;
        logic prev_en;
        int want[5] = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        step(4'b0000);
        rst = 1'b0;
        prev_en = 1'b0;
        tos = 0;
        for (int i = 0; i < 24; i++) begin
            step(4'b1111);
            checks++;
            if ({grant_en, grant_idx, timeout, busy} !== {m_en, 2'(m_idx), m_to, m_en | m_gap}) begin
                errors++;
                $display("FAIL all_hold cyc=%0d got en=%b idx=%0d to=%b busy=%b want en=%b idx=%0d to=%b busy=%b",
                         i, grant_en, grant_idx, timeout, busy, m_en, m_idx, m_to, m_en | m_gap);
            end
            if (grant_en && !prev_en) starts.push_back(int'(grant_idx));
            if (timeout) tos++;
            prev_en = grant_en;
        end
        for (int g = 0; g < 5; g++) begin
            checks++;
            if (g >= starts.size() || starts[g] != want[g]) begin
                errors++;
                $display("FAIL all_hold_order grant=%0d got %0d want %0d",
                         g, (g < starts.size()) ? starts[g] : -1, want[g]);
            end
        end
        checks++;
        if (tos != 4) begin
            errors++;
            $display("FAIL all_hold_timeouts got %0d want 4", tos);
        end
    endtask

    task automatic test_single_hold();
        int tos;
        step(4'b0000);
        step(4'b0000);
        tos = 0;
        for (int i = 0; i < 10; i++) begin
            step(4'b0001);
            checks++;
            if ({grant_en, grant_idx, timeout, busy} !== {m_en, 2'(m_idx), m_to, m_en | m_gap}) begin
                errors++;
                $display("FAIL single_hold cyc=%0d got en=%b idx=%0d to=%b busy=%b want en=%b idx=%0d to=%b busy=%b",
                         i, grant_en, grant_idx, timeout, busy, m_en, m_idx, m_to, m_en | m_gap);
            end
            if (timeout) begin
                tos++;
                checks++;
                if (grant_en !== 1'b0 || (i != 4 && i != 9)) begin
                    errors++;
                    $display("FAIL single_hold_timeout cyc=%0d got en=%b want en=0 at cyc 4 or 9", i, grant_en);
                end
            end
        end
        checks++;
        if (tos != 2) begin
            errors++;
            $display("FAIL single_hold_count got %0d want 2", tos);
        end
    endtask

    task automatic test_release_at_limit();
        step(4'b0000);
        step(4'b0000);
        for (int i = 0; i < 4; i++) step(4'b0010);
        checks++;
        if (grant_en !== 1'b1 || grant_idx !== 2'd1) begin
            errors++;
            $display("FAIL limit_pre got en=%b idx=%0d want en=1 idx=1", grant_en, grant_idx);
        end
        step(4'b0000);
        checks++;
        if (grant_en !== 1'b0 || busy !== 1'b1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL limit_release got en=%b busy=%b to=%b want en=0 busy=1 to=0",
                     grant_en, busy, timeout);
        end
    endtask

    task automatic test_async_reset();
        step(4'b0000);
        step(4'b0000);
        step(4'b1000);
        step(4'b1000);
        checks++;
        if (grant_en !== 1'b1 || grant_idx !== 2'd3) begin
            errors++;
            $display("FAIL async_pre got en=%b idx=%0d want en=1 idx=3", grant_en, grant_idx);
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({grant_en, busy, grant_idx, timeout} !== 5'b00000) begin
            errors++;
            $display("FAIL async_clear got en=%b busy=%b idx=%0d to=%b want all 0",
                     grant_en, busy, grant_idx, timeout);
        end
        step(4'b1001);
        rst = 1'b0;
        step(4'b1001);
        checks++;
        if (grant_en !== 1'b1 || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL async_first got en=%b idx=%0d want en=1 idx=0", grant_en, grant_idx);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3, 0) == 0) r = 4'($urandom_range(15, 0));
            step(r);
            checks++;
            if ({grant_en, grant_idx, timeout, busy} !== {m_en, 2'(m_idx), m_to, m_en | m_gap}) begin
                errors++;
                $display("FAIL random cyc=%0d req=%b got en=%b idx=%0d to=%b busy=%b want en=%b idx=%0d to=%b busy=%b",
                         i, r, grant_en, grant_idx, timeout, busy, m_en, m_idx, m_to, m_en | m_gap);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_release();
        test_all_hold();
        test_single_hold();
        test_release_at_limit();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
